mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's load/store path. It accepts one request at a time (word, halfword or byte; read or write) over a valid/ready handshake. After a configurable number of wait states it returns a response: read data or a write acknowledge, plus an error flag. It lets the control FSM be exercised against a memory with non-zero, stallable latency instead of a fixed one-cycle array.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_byte_lane.sv | 38 +++
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: transfer sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSV  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian lane steering: merges store data into a word and extracts
// zero-extended load data for word/half/byte accesses.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  always_comb begin
    st_word    = old_word;
    ld_data    = '0;
    misaligned = 1'b0;
    case (size)
      SIZE_WORD: begin
        misaligned = |lane;
        st_word    = wdata;
        ld_data    = old_word;
      end
      SIZE_HALF: begin
        misaligned                      = lane[0];
        st_word[{lane[1], 4'b0} +: 16] = wdata[15:0];
        ld_data[15:0]                   = old_word[{lane[1], 4'b0} +: 16];
      end
      SIZE_BYTE: begin
        st_word[{lane, 3'b0} +: 8] = wdata[7:0];
        ld_data[7:0]               = old_word[{lane, 3'b0} +: 8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with configurable wait states, used to
// exercise the CPU load/store path against a stallable memory.
//
// state   | meaning
// IDLE    | ready for a request; req_ready high once out of reset
// WAIT    | request latched, counting down wait states
// RESP    | response held on resp_* until resp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDXW       = $clog2(DEPTH);
  localparam int unsigned CW         = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lat_write_q, lat_write_d;
  logic [1:0]    lat_size_q, lat_size_d;
  logic [31:0]   lat_addr_q, lat_addr_d;
  logic [31:0]   lat_wdata_q, lat_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic [31:0]   mem_q [DEPTH];

  logic          accept, do_access, mem_we;
  logic          acc_write, in_range, acc_err, misaligned;
  logic [1:0]    acc_size;
  logic [31:0]   acc_addr, acc_wdata;
  logic [IDXW-1:0] idx;
  logic [31:0]   old_word, st_word, ld_data;

  assign req_ready  = (state_q == ST_IDLE) && reset;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign accept     = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so it must
  // see the live request rather than the latched copy.
  assign acc_write = (state_q == ST_IDLE) ? req_write : lat_write_q;
  assign acc_size  = (state_q == ST_IDLE) ? req_size  : lat_size_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : lat_addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : lat_wdata_q;

  assign idx      = acc_addr[IDXW+1:2];
  assign old_word = mem_q[idx];
  assign in_range = {1'b0, acc_addr} < ADDR_LIMIT;
  assign acc_err  = misaligned || !in_range || (acc_size == SIZE_RSV);
  assign mem_we   = do_access && acc_write && !acc_err;

  mem_byte_lane u_lane (
    .size       (acc_size),
    .lane       (acc_addr[1:0]),
    .old_word   (old_word),
    .wdata      (acc_wdata),
    .st_word    (st_word),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_size_d  = lat_size_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    do_access   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lat_write_d = req_write;
          lat_size_d  = req_size;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_access) begin
      error_d = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'h0 : ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_size_q  <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_size_q  <= lat_size_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  // Storage is deliberately not reset; contents survive a mid-operation reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= st_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2 instance driven from a vector table
// with a response scoreboard, plus a WAIT_STATES=0 instance run back-to-back.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int WS = 2;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;

  logic        req_valid_z = 1'b0, req_write_z = 1'b0, resp_ready_z = 1'b1;
  logic [1:0]  req_size_z = '0;
  logic [31:0] req_addr_z = '0, req_wdata_z = '0;
  logic        req_ready_z, resp_valid_z, resp_error_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int failures = 0;

  vec_t vecs[$];
  vec_t zvecs[$];
  exp_t sb[$];
  exp_t sb_z[$];

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(256), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_z (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_size(req_size_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_error(resp_error_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                              input int hold);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.hold = hold;
    return v;
  endfunction

  // Entered and left at a negedge.
  task automatic do_txn(input vec_t v);
    exp_t e;
    int   n;
    int   lat;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_addr  = v.addr; req_wdata = v.wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", {31'b0, req_ready}, 32'd1);
      void'(sb.pop_front());
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    // scramble the request after acceptance; the responder must ignore it
    req_valid = 1'b0; req_write = ~v.wr; req_size = ~v.size;
    req_addr  = ~v.addr; req_wdata = ~v.wdata;
    lat = 1;
    while (resp_valid !== 1'b1 && lat <= 20) begin
      check("wait_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clock);
      lat++;
    end
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", {31'b0, resp_valid}, 32'd1);
      void'(sb.pop_front());
      return;
    end
    check("latency", lat, WS + 1);
    e = sb.pop_front();
    for (int h = 0; h < v.hold; h++) begin
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_rdata", resp_rdata, e.rdata);
      @(negedge clock);
    end
    check("rdata", resp_rdata, e.rdata);
    check("error", {31'b0, resp_error}, {31'b0, e.err});
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("valid_cleared", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(1, SIZE_WORD, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h10,  32'h0,        32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, SIZE_BYTE, 32'h11,  32'h123456AA, 32'h0,        0, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h10,  32'h0,        32'hDEADAAEF, 0, 0));
    vecs.push_back(mk(0, SIZE_BYTE, 32'h13,  32'h0,        32'h000000DE, 0, 0));
    vecs.push_back(mk(0, SIZE_HALF, 32'h12,  32'h0,        32'h0000DEAD, 0, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h12,  32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, SIZE_WORD, 32'h403, 32'h55555555, 32'h0,        1, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h400, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, SIZE_WORD, 32'h12,  32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, SIZE_HALF, 32'h11,  32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, SIZE_RSV,  32'h10,  32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h10,  32'h0,        32'hDEADAAEF, 0, 0));
    vecs.push_back(mk(1, SIZE_WORD, 32'h20,  32'h12345678, 32'h0,        0, 5));
    vecs.push_back(mk(0, SIZE_WORD, 32'h20,  32'h0,        32'h12345678, 0, 2));
    vecs.push_back(mk(1, SIZE_HALF, 32'h22,  32'hABCDCAFE, 32'h0,        0, 0));
    vecs.push_back(mk(0, SIZE_WORD, 32'h20,  32'h0,        32'hCAFE5678, 0, 0));
    vecs.push_back(mk(0, SIZE_HALF, 32'h20,  32'h0,        32'h00005678, 0, 0));
    vecs.push_back(mk(1, SIZE_BYTE, 32'h3FF, 32'h0000005A, 32'h0,        0, 0));
    vecs.push_back(mk(0, SIZE_BYTE, 32'h3FF, 32'h0,        32'h0000005A, 0, 0));
    vecs.push_back(mk(0, SIZE_BYTE, 32'h400, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, SIZE_WORD, 32'h30,  32'h0BADF00D, 32'h0,        0, 0));

    zvecs.push_back(mk(1, SIZE_WORD, 32'h8,   32'h11223344, 32'h0,        0, 0));
    zvecs.push_back(mk(0, SIZE_WORD, 32'h8,   32'h0,        32'h11223344, 0, 0));
    zvecs.push_back(mk(1, SIZE_BYTE, 32'h9,   32'h00000077, 32'h0,        0, 0));
    zvecs.push_back(mk(0, SIZE_WORD, 32'h8,   32'h0,        32'h11227744, 0, 0));
    zvecs.push_back(mk(0, SIZE_HALF, 32'hA,   32'h0,        32'h00001122, 0, 0));
    zvecs.push_back(mk(0, SIZE_WORD, 32'h3FE, 32'h0,        32'h0,        1, 0));

    // reset asserted from time 0
    @(negedge clock);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", {31'b0, resp_error}, 32'd0);
    check("rst_req_ready_z", {31'b0, req_ready_z}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) do_txn(vecs[i]);

    // store 0xFFFFFFFF to 0x30, then reset while it is still waiting
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD;
    req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'h0);
    check("mid_rst_error", {31'b0, resp_error}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle", {31'b0, req_ready}, 32'd1);
    check("post_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    do_txn(mk(0, SIZE_WORD, 32'h30, 32'h0, 32'h0BADF00D, 0, 0));

    // zero-wait-state instance: requests held back-to-back, resp_ready always 1
    begin
      exp_t e;
      e.rdata = zvecs[0].exp_rdata; e.err = zvecs[0].exp_err;
      sb_z.push_back(e);
      req_valid_z = 1'b1; req_write_z = zvecs[0].wr; req_size_z = zvecs[0].size;
      req_addr_z = zvecs[0].addr; req_wdata_z = zvecs[0].wdata;
      for (int k = 0; k < zvecs.size(); k++) begin
        check("z_req_ready_on", {31'b0, req_ready_z}, 32'd1);
        @(negedge clock);
        check("z_resp_valid", {31'b0, resp_valid_z}, 32'd1);
        check("z_req_ready_off", {31'b0, req_ready_z}, 32'd0);
        e = sb_z.pop_front();
        check("z_rdata", resp_rdata_z, e.rdata);
        check("z_error", {31'b0, resp_error_z}, {31'b0, e.err});
        if (k + 1 < zvecs.size()) begin
          e.rdata = zvecs[k+1].exp_rdata; e.err = zvecs[k+1].exp_err;
          sb_z.push_back(e);
          req_write_z = zvecs[k+1].wr; req_size_z = zvecs[k+1].size;
          req_addr_z = zvecs[k+1].addr; req_wdata_z = zvecs[k+1].wdata;
        end else begin
          req_valid_z = 1'b0;
        end
        @(negedge clock);
      end
      check("z_final_valid", {31'b0, resp_valid_z}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
